// File: rtl/aes_mix_columns_iter.sv
// AES MixColumns / InvMixColumns engine that handles COLS_PER_CYCLE state columns per clock.
// Latency: N = 4/COLS_PER_CYCLE edges from the accept edge to Out_Valid high.
// Backpressure: the result is held in DONE while Out_Ready=0. In_Ready is low throughout BUSY.
// Ports:
//   Clk/Rst            rising-edge clock, async active-high reset
//   In_Valid/In_Ready  input handshake; In_Data (state) and In_Mode (0=fwd, 1=inv) captured at accept
//   Out_Valid/Out_Ready output handshake; Out_Data holds the transformed state
//   Busy               high while columns are being transformed
module aes_mix_columns_iter #(
  parameter int BUS_WIDTH      = 128,
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [BUS_WIDTH-1:0] In_Data,
  input  logic                 In_Mode,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [BUS_WIDTH-1:0] Out_Data,
  output logic                 Busy
);

  generate
    if (BUS_WIDTH != 128) begin : g_bad_width
      $error("aes_mix_columns_iter: BUS_WIDTH must be 128");
    end
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Counter advance per BUSY cycle; 4 truncates to 0 so COLS_PER_CYCLE=4 finishes in one cycle.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_next;
  logic [1:0]           cnt;
  logic [BUS_WIDTH-1:0] in_reg;
  logic                 mode_reg;
  logic [BUS_WIDTH-1:0] res_reg;
  logic [BUS_WIDTH-1:0] res_next;
  logic [BUS_WIDTH-1:0] out_reg;
  logic                 accept;
  logic                 last_slice;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant of at most 4 bits (all MixColumns coefficients fit).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // One column, row r in bits [8r+7:8r]. Circulant matrix: o_i = sum_j k[(j-i) mod 4] * a_j.
  function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
    logic [3:0]  k [4];
    logic [31:0] o;
    k[0] = inv ? 4'he : 4'h2;
    k[1] = inv ? 4'hb : 4'h3;
    k[2] = inv ? 4'hd : 4'h1;
    k[3] = inv ? 4'h9 : 4'h1;
    o    = 32'h0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        o[8*i +: 8] = o[8*i +: 8] ^ gmul(a[8*j +: 8], k[2'(j - i)]);
      end
    end
    return o;
  endfunction

  // Column c of row r lives at bits [32r+31-8c : 32r+24-8c].
  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
    logic [31:0] o;
    o = 32'h0;
    for (int r = 0; r < 4; r++) o[8*r +: 8] = s[32*r + 24 - 8*int'(c) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] put_col(input logic [127:0] s, input logic [1:0] c,
                                           input logic [31:0] col);
    logic [127:0] o;
    o = s;
    for (int r = 0; r < 4; r++) o[32*r + 24 - 8*int'(c) +: 8] = col[8*r +: 8];
    return o;
  endfunction

  // Result register with the current slice of columns replaced by their transform.
  always_comb begin
    res_next = res_reg;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      res_next = put_col(res_next, cnt + 2'(k), mix_col(get_col(in_reg, cnt + 2'(k)), mode_reg));
    end
  end

  assign last_slice = (cnt == CNT_LAST);
  assign accept     = In_Valid & In_Ready;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    In_Ready   = 1'b0;
    Out_Valid  = 1'b0;
    case (state)
      IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        Out_Valid = 1'b1;
        // Same-cycle handoff: the slot frees as soon as downstream takes the result.
        In_Ready  = Out_Ready;
        if (Out_Ready) state_next = In_Valid ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Partial results accumulate in res_reg; Out_Data is loaded only once the last slice is done,
  // so it never shows a half-transformed state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      in_reg   <= '0;
      mode_reg <= 1'b0;
      res_reg  <= '0;
      out_reg  <= '0;
      cnt      <= 2'd0;
    end else if (accept) begin
      in_reg   <= In_Data;
      mode_reg <= In_Mode;
      cnt      <= 2'd0;
    end else if (state == BUSY) begin
      res_reg <= res_next;
      cnt     <= cnt + CNT_STEP;
      if (last_slice) out_reg <= res_next;
    end
  end

  assign Out_Data = out_reg;
  assign Busy     = (state == BUSY);

endmodule
